// File: rtl/perm_round_sequencer_if.sv
// Purpose: handshake and memory-side bus of the permutation round sequencer.
// Ports (signals):
//   start, n_blocks, base_addr         : job request from the requester (master)
//   ready, busy, done                  : job status from the sequencer (slave)
//   rd_en, rd_addr, ld_en, ld_idx      : input memory read and state-slice load
//   round_en, round_idx                : permutation round strobe and constant index
//   wr_en, wr_idx, wr_addr, blk_idx    : output memory write and block progress
interface perm_round_sequencer_if #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned SLICE_W = 6,
  parameter int unsigned ROUND_W = 5,
  parameter int unsigned BLK_W   = 8
);
  logic               start;
  logic [BLK_W-1:0]   n_blocks;
  logic [ADDR_W-1:0]  base_addr;
  logic               ready;
  logic               busy;
  logic               done;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic               ld_en;
  logic [SLICE_W-1:0] ld_idx;
  logic               round_en;
  logic [ROUND_W-1:0] round_idx;
  logic               wr_en;
  logic [SLICE_W-1:0] wr_idx;
  logic [ADDR_W-1:0]  wr_addr;
  logic [BLK_W-1:0]   blk_idx;

  // Requester side
  modport master (
    output start, n_blocks, base_addr,
    input  ready, busy, done, rd_en, rd_addr, ld_en, ld_idx,
           round_en, round_idx, wr_en, wr_idx, wr_addr, blk_idx
  );

  // Sequencer side
  modport slave (
    input  start, n_blocks, base_addr,
    output ready, busy, done, rd_en, rd_addr, ld_en, ld_idx,
           round_en, round_idx, wr_en, wr_idx, wr_addr, blk_idx
  );
endinterface

// File: rtl/perm_round_sequencer.sv
// Purpose: sequences the permutation datapath over a batch of state blocks:
// per block it loads NUM_SLICES slices, runs NUM_ROUNDS rounds, then writes
// NUM_SLICES slices back, with a start/ready/done handshake.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : perm_round_sequencer_if.slave (handshake, read/load, round, write)
// All bus outputs are flops; their next values are decoded from the next
// state and next counters, so no input has a combinational path to an output.
module perm_round_sequencer #(
  parameter int unsigned NUM_SLICES = 64,
  parameter int unsigned NUM_ROUNDS = 24,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned SLICE_W    = 6,
  parameter int unsigned ROUND_W    = 5,
  parameter int unsigned BLK_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  perm_round_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_LOAD_WAIT = 3'd2;
  localparam logic [2:0] S_ROUND     = 3'd3;
  localparam logic [2:0] S_WRITE     = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  localparam logic [SLICE_W-1:0] SLICE_LAST = SLICE_W'(NUM_SLICES - 1);
  localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(NUM_ROUNDS - 1);
  localparam logic [ADDR_W-1:0]  BLK_STRIDE = ADDR_W'(NUM_SLICES);

  // State and counters
  logic [2:0]         r_state,     w_state_nxt;
  logic [SLICE_W-1:0] r_slice_cnt, w_slice_nxt;
  logic [ROUND_W-1:0] r_round_cnt, w_round_nxt;
  logic [BLK_W-1:0]   r_blk_cnt,   w_blk_nxt;
  logic [BLK_W-1:0]   r_blk_total, w_total_nxt;
  logic [ADDR_W-1:0]  r_base_q,    w_base_nxt;

  // Registered outputs and their next values
  logic               r_ready,     w_ready_nxt;
  logic               r_busy,      w_busy_nxt;
  logic               r_done,      w_done_nxt;
  logic               r_rd_en,     w_rd_en_nxt;
  logic [ADDR_W-1:0]  r_rd_addr,   w_rd_addr_nxt;
  logic               r_round_en,  w_round_en_nxt;
  logic [ROUND_W-1:0] r_round_idx, w_round_idx_nxt;
  logic               r_wr_en,     w_wr_en_nxt;
  logic [SLICE_W-1:0] r_wr_idx,    w_wr_idx_nxt;
  logic [ADDR_W-1:0]  r_wr_addr,   w_wr_addr_nxt;

  // Load pipeline: one cycle behind the read strobe (memory latency 1)
  logic               r_ld_en;
  logic [SLICE_W-1:0] r_ld_idx;

  // Memory address of a slice within a batch, wrapping at ADDR_W bits
  function automatic logic [ADDR_W-1:0] slice_addr(
    input logic [ADDR_W-1:0]  base,
    input logic [BLK_W-1:0]   blk,
    input logic [SLICE_W-1:0] slice
  );
    slice_addr = base + ADDR_W'(blk) * BLK_STRIDE + ADDR_W'(slice);
  endfunction

  // Next-state and counter update
  always_comb begin
    w_state_nxt = r_state;
    w_slice_nxt = r_slice_cnt;
    w_round_nxt = r_round_cnt;
    w_blk_nxt   = r_blk_cnt;
    w_total_nxt = r_blk_total;
    w_base_nxt  = r_base_q;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          // A zero block count is run as a single block
          w_total_nxt = (bus.n_blocks == '0) ? BLK_W'(1) : bus.n_blocks;
          w_base_nxt  = bus.base_addr;
          w_slice_nxt = '0;
          w_blk_nxt   = '0;
          w_state_nxt = S_LOAD;
        end
      end

      S_LOAD: begin
        if (r_slice_cnt == SLICE_LAST) begin
          w_slice_nxt = '0;
          w_state_nxt = S_LOAD_WAIT;
        end else begin
          w_slice_nxt = r_slice_cnt + SLICE_W'(1);
        end
      end

      S_LOAD_WAIT: begin
        w_round_nxt = '0;
        w_state_nxt = S_ROUND;
      end

      S_ROUND: begin
        if (r_round_cnt == ROUND_LAST) begin
          w_round_nxt = '0;
          w_state_nxt = S_WRITE;
        end else begin
          w_round_nxt = r_round_cnt + ROUND_W'(1);
        end
      end

      S_WRITE: begin
        if (r_slice_cnt == SLICE_LAST) begin
          w_slice_nxt = '0;
          if (r_blk_cnt == r_blk_total - BLK_W'(1)) begin
            w_state_nxt = S_DONE;
          end else begin
            // Next block starts loading with no idle cycle in between
            w_blk_nxt   = r_blk_cnt + BLK_W'(1);
            w_state_nxt = S_LOAD;
          end
        end else begin
          w_slice_nxt = r_slice_cnt + SLICE_W'(1);
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state/counters, registered below
  always_comb begin
    w_ready_nxt     = 1'b0;
    w_busy_nxt      = 1'b0;
    w_done_nxt      = 1'b0;
    w_rd_en_nxt     = 1'b0;
    w_rd_addr_nxt   = '0;
    w_round_en_nxt  = 1'b0;
    w_round_idx_nxt = '0;
    w_wr_en_nxt     = 1'b0;
    w_wr_idx_nxt    = '0;
    w_wr_addr_nxt   = '0;

    w_ready_nxt = (w_state_nxt == S_IDLE);
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_done_nxt  = (w_state_nxt == S_DONE);

    if (w_state_nxt == S_LOAD) begin
      w_rd_en_nxt   = 1'b1;
      w_rd_addr_nxt = slice_addr(w_base_nxt, w_blk_nxt, w_slice_nxt);
    end

    if (w_state_nxt == S_ROUND) begin
      w_round_en_nxt  = 1'b1;
      w_round_idx_nxt = w_round_nxt;
    end

    if (w_state_nxt == S_WRITE) begin
      w_wr_en_nxt   = 1'b1;
      w_wr_idx_nxt  = w_slice_nxt;
      w_wr_addr_nxt = slice_addr(w_base_nxt, w_blk_nxt, w_slice_nxt);
    end
  end

  // State, counter, output and load-pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_slice_cnt <= '0;
      r_round_cnt <= '0;
      r_blk_cnt   <= '0;
      r_blk_total <= '0;
      r_base_q    <= '0;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_round_en  <= 1'b0;
      r_round_idx <= '0;
      r_wr_en     <= 1'b0;
      r_wr_idx    <= '0;
      r_wr_addr   <= '0;
      r_ld_en     <= 1'b0;
      r_ld_idx    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_slice_cnt <= w_slice_nxt;
      r_round_cnt <= w_round_nxt;
      r_blk_cnt   <= w_blk_nxt;
      r_blk_total <= w_total_nxt;
      r_base_q    <= w_base_nxt;
      r_ready     <= w_ready_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_rd_en     <= w_rd_en_nxt;
      r_rd_addr   <= w_rd_addr_nxt;
      r_round_en  <= w_round_en_nxt;
      r_round_idx <= w_round_idx_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_wr_idx    <= w_wr_idx_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      // While rd_en is high, r_slice_cnt is the slice being read
      r_ld_en     <= r_rd_en;
      r_ld_idx    <= r_rd_en ? r_slice_cnt : '0;
    end
  end

  assign bus.ready     = r_ready;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.rd_en     = r_rd_en;
  assign bus.rd_addr   = r_rd_addr;
  assign bus.ld_en     = r_ld_en;
  assign bus.ld_idx    = r_ld_idx;
  assign bus.round_en  = r_round_en;
  assign bus.round_idx = r_round_idx;
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_idx    = r_wr_idx;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.blk_idx   = r_blk_cnt;

endmodule

// File: tb/tb_perm_round_sequencer.sv
// Purpose: self-checking bench for perm_round_sequencer. Every cycle of a job
// is compared against a job-level reference timeline computed arithmetically
// from the block/round/slice counts.
module tb_perm_round_sequencer;

  localparam int NS  = 64;
  localparam int NR  = 24;
  localparam int PER = 2 * NS + 1 + NR;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  perm_round_sequencer_if bus ();

  perm_round_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          rd, rnd, wr, done, ready, busy;
    logic [15:0] addr;
    logic [5:0]  idx;
    logic [7:0]  blk;
  } exp_t;

  typedef struct {
    int          nb;
    logic [15:0] base;
    int          lat;
    logic [15:0] first_rd;
    logic [15:0] last_wr;
  } vec_t;

  // Expected activity in cycle cyc after the accept edge (cyc<=0: idle before)
  function automatic exp_t model(input int nbe, input logic [15:0] base, input int cyc);
    exp_t e;
    int b, o;
    e = '{default: '0};
    if (cyc <= 0) begin
      e.ready = 1'b1;
      return e;
    end
    if (cyc == nbe * PER + 1) begin
      e.done = 1'b1; e.busy = 1'b1; e.blk = 8'(nbe - 1);
      return e;
    end
    if (cyc > nbe * PER + 1) begin
      e.ready = 1'b1; e.blk = 8'(nbe - 1);
      return e;
    end
    e.busy = 1'b1;
    b = (cyc - 1) / PER;
    o = (cyc - 1) % PER;
    e.blk = 8'(b);
    if (o < NS) begin
      e.rd = 1'b1; e.addr = 16'(int'(base) + b * NS + o); e.idx = 6'(o);
    end else if (o > NS && o < NS + 1 + NR) begin
      e.rnd = 1'b1; e.idx = 6'(o - NS - 1);
    end else if (o >= NS + 1 + NR) begin
      e.wr = 1'b1; e.addr = 16'(int'(base) + b * NS + o - NS - 1 - NR);
      e.idx = 6'(o - NS - 1 - NR);
    end
    return e;
  endfunction

  // Expected signature: cur = this cycle, prv = previous cycle (drives ld_*)
  function automatic logic [63:0] sig_exp(input exp_t cur, input exp_t prv);
    logic [4:0] ridx;
    ridx = cur.rnd ? cur.idx[4:0] : 5'd0;
    return {cur.rd, prv.rd, cur.rnd, cur.wr, cur.done, cur.ready, cur.busy, cur.blk,
            cur.rd ? cur.addr : 16'd0, prv.rd ? prv.idx : 6'd0, ridx,
            cur.wr ? cur.addr : 16'd0, cur.wr ? cur.idx : 6'd0};
  endfunction

  function automatic logic [63:0] sig_act();
    return {bus.rd_en, bus.ld_en, bus.round_en, bus.wr_en, bus.done, bus.ready, bus.busy,
            bus.blk_idx,
            bus.rd_en ? bus.rd_addr : 16'd0, bus.ld_en ? bus.ld_idx : 6'd0,
            bus.round_en ? bus.round_idx : 5'd0,
            bus.wr_en ? bus.wr_addr : 16'd0, bus.wr_en ? bus.wr_idx : 6'd0};
  endfunction

  task automatic check(input string name, input int cyc, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Follows a job from the cycle after its accept edge to its first idle cycle
  task automatic trace_job(input int nb, input logic [15:0] base, input bit keep,
                           input int nxt_nb, input logic [15:0] nxt_base,
                           output logic [15:0] first_rd, output logic [15:0] last_wr,
                           output int done_cyc);
    int nbe, last;
    bit got_rd;
    nbe = (nb == 0) ? 1 : nb;
    last = nbe * PER + 2;
    first_rd = '0; last_wr = '0; done_cyc = -1; got_rd = 1'b0;
    for (int cyc = 1; cyc <= last; cyc++) begin
      @(negedge clk);
      check("trace", cyc, sig_act(), sig_exp(model(nbe, base, cyc), model(nbe, base, cyc - 1)));
      if (bus.rd_en && !got_rd) begin first_rd = bus.rd_addr; got_rd = 1'b1; end
      if (bus.wr_en) last_wr = bus.wr_addr;
      if (bus.done && done_cyc < 0) done_cyc = cyc;
      if (cyc < last - 1) begin
        // Noise on the request inputs while busy must be ignored
        bus.start     = keep ? 1'b1 : 1'($urandom_range(0, 1));
        bus.n_blocks  = 8'($urandom);
        bus.base_addr = 16'($urandom);
      end else if (cyc == last - 1) begin
        bus.start     = keep;
        bus.n_blocks  = 8'(nxt_nb);
        bus.base_addr = nxt_base;
      end
    end
  endtask

  task automatic run_job(input int nb, input logic [15:0] base, input bit keep,
                         input int nxt_nb, input logic [15:0] nxt_base,
                         output logic [15:0] first_rd, output logic [15:0] last_wr,
                         output int done_cyc);
    @(negedge clk);
    bus.start = 1'b1; bus.n_blocks = 8'(nb); bus.base_addr = base;
    @(posedge clk);
    trace_job(nb, base, keep, nxt_nb, nxt_base, first_rd, last_wr, done_cyc);
  endtask

  vec_t vecs[4];

  initial begin
    logic [15:0] fr, lw;
    int dc, nb, dones;
    logic [15:0] base;

    vecs[0] = '{nb: 1, base: 16'h0100, lat: 154, first_rd: 16'h0100, last_wr: 16'h013F};
    vecs[1] = '{nb: 3, base: 16'h1000, lat: 460, first_rd: 16'h1000, last_wr: 16'h10BF};
    vecs[2] = '{nb: 0, base: 16'h2000, lat: 154, first_rd: 16'h2000, last_wr: 16'h203F};
    vecs[3] = '{nb: 1, base: 16'hFFE0, lat: 154, first_rd: 16'hFFE0, last_wr: 16'h001F};

    rst = 1'b1; bus.start = 1'b0; bus.n_blocks = '0; bus.base_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", 0, sig_act(), sig_exp(model(1, 16'h0, 0), model(1, 16'h0, -1)));
    rst = 1'b0;

    // Directed jobs from the table
    foreach (vecs[i]) begin
      run_job(vecs[i].nb, vecs[i].base, 1'b0, 0, 16'h0, fr, lw, dc);
      check("done_latency", i, 64'(dc), 64'(vecs[i].lat));
      check("first_rd_addr", i, 64'(fr), 64'(vecs[i].first_rd));
      check("last_wr_addr", i, 64'(lw), 64'(vecs[i].last_wr));
    end

    // start held high: second job accepted on the first idle cycle after done
    run_job(2, 16'h3000, 1'b1, 1, 16'h5000, fr, lw, dc);
    check("held_start_lat1", 0, 64'(dc), 64'(307));
    @(posedge clk);
    trace_job(1, 16'h5000, 1'b0, 0, 16'h0, fr, lw, dc);
    check("held_start_lat2", 0, 64'(dc), 64'(154));
    check("held_start_rd", 0, 64'(fr), 64'(16'h5000));

    // Reset in the middle of ROUND at round index 10
    @(negedge clk);
    bus.start = 1'b1; bus.n_blocks = 8'd1; bus.base_addr = 16'h4000;
    @(posedge clk);
    for (int cyc = 1; cyc <= NS + 1 + 11; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      check("pre_reset", cyc, sig_act(), sig_exp(model(1, 16'h4000, cyc), model(1, 16'h4000, cyc - 1)));
    end
    check("round_idx_10", 0, 64'({bus.round_en, bus.round_idx}), 64'({1'b1, 5'd10}));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid_reset", 0, sig_act(), sig_exp(model(1, 16'h0, 0), model(1, 16'h0, -1)));
    dones = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("no_done_after_reset", 0, 64'(dones), 64'(0));
    run_job(1, 16'h4000, 1'b0, 0, 16'h0, fr, lw, dc);
    check("clean_restart_lat", 0, 64'(dc), 64'(154));
    check("clean_restart_rd", 0, 64'(fr), 64'(16'h4000));

    // Randomized jobs against the reference timeline
    for (int k = 0; k < 4; k++) begin
      nb = int'($urandom_range(0, 3));
      base = 16'($urandom);
      run_job(nb, base, 1'b0, 0, 16'h0, fr, lw, dc);
      check("rand_done_lat", k, 64'(dc), 64'(((nb == 0) ? 1 : nb) * PER + 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/perm_round_sequencer.md
Name: perm_round_sequencer

Overview:
- Control unit that sequences the Keccak-style permutation datapath over one or more consecutive state blocks.
- Per block: streams NUM_SLICES 25-bit slices from input memory into the state register, issues NUM_ROUNDS round-enable cycles with the round index, then streams NUM_SLICES slices to output memory.
- Replaces the single-shot cu/counter pair. Adds a start/ready/done handshake and multi-block batching with address generation.

Parameters:
- NUM_SLICES, 64, slices per state block (≥2).
- NUM_ROUNDS, 24, rounds per block (≥1).
- ADDR_W, 16, memory address width.
- SLICE_W, 6, slice index width, ≥ clog2(NUM_SLICES).
- ROUND_W, 5, round index width, ≥ clog2(NUM_ROUNDS).
- BLK_W, 8, block count width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only while ready=1.
- n_blocks  in  BLK_W  number of blocks to process; sampled on accepted start; 0 is treated as 1.
- base_addr  in  ADDR_W  first memory address for read and write; sampled on accepted start.
- ready  out  1  high in IDLE only.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last block's final write.
- rd_en  out  1  input memory read strobe.
- rd_addr  out  ADDR_W  input memory address.
- ld_en  out  1  load state slice; rd_en delayed by 1 cycle (memory read latency 1).
- ld_idx  out  SLICE_W  slice index for ld_en; slice counter delayed by 1 cycle.
- round_en  out  1  datapath executes one round this cycle.
- round_idx  out  ROUND_W  round constant index.
- wr_en  out  1  output memory write strobe; data is the state slice wr_idx.
- wr_idx  out  SLICE_W  slice selected for output.
- wr_addr  out  ADDR_W  output memory address.
- blk_idx  out  BLK_W  index of the block in progress, starting at 0.

Behaviour:
- States: IDLE, LOAD, LOAD_WAIT, ROUND, WRITE, DONE. Registers: state, slice_cnt, round_cnt, blk_cnt, blk_total, base_q, ld pipeline flop pair.
- Reset (rst=1 at a clock edge): state=IDLE; all counters and registers 0; ld pipeline cleared. Outputs: ready=1, every other output 0. Reset overrides any state, including mid-LOAD or mid-WRITE. Memory side effects already issued are not undone.
- IDLE: ready=1. On start=1:
  - latch blk_total = (n_blocks==0 ? 1 : n_blocks) and base_q = base_addr;
  - clear slice_cnt and blk_cnt;
  - next state LOAD.
- start while not IDLE is ignored. No queuing.
- LOAD: rd_en=1, rd_addr = base_q + blk_cnt*NUM_SLICES + slice_cnt (ADDR_W wrap-around, no saturation). slice_cnt increments each cycle. On slice_cnt==NUM_SLICES-1: slice_cnt←0, next state LOAD_WAIT.
- LOAD_WAIT: one cycle; lets the last ld_en land. round_cnt←0, next state ROUND.
- ld_en/ld_idx follow rd_en/slice_cnt with exactly one cycle delay; ld_en is never high in ROUND.
- ROUND: round_en=1, round_idx=round_cnt. round_cnt increments each cycle. On round_cnt==NUM_ROUNDS-1: next state WRITE.
- WRITE: wr_en=1, wr_idx=slice_cnt, wr_addr = same formula as rd_addr. On slice_cnt==NUM_SLICES-1: slice_cnt←0.
  - If blk_cnt==blk_total-1: next state DONE.
  - Otherwise blk_cnt increments and next state is LOAD (no idle cycle between blocks).
- DONE: done=1 for one cycle, busy=1. Next state IDLE. A start in DONE is ignored; it is accepted from the following cycle.
- blk_idx = blk_cnt at all times.
- Outputs are decoded from registered state/counters: no combinational path from start to any output.
- Cycles per block: 2*NUM_SLICES + 1 + NUM_ROUNDS (153 at defaults).
- Total from start-accept edge to done high: blk_total*153 + 1 cycles (first LOAD cycle follows the accept edge).
- At most one of rd_en, round_en, wr_en is high in any cycle.

Test Plan:
- Reset then single block: rst 2 cycles, start=1 for 1 cycle, n_blocks=1, base_addr=0x0100.
  - rd_addr runs 0x0100..0x013F over 64 cycles.
  - ld_en is high for 64 cycles, 1 cycle behind rd_en.
  - round_idx runs 0..23.
  - wr_addr runs 0x0100..0x013F.
  - done pulses once, 154 cycles after the accept edge; ready returns to 1.
- Batch: n_blocks=3, base_addr=0x1000.
  - Second block reads 0x1040..0x107F; third block writes 0x1080..0x10BF.
  - Block 1's last WRITE cycle is directly followed by block 2's first LOAD.
  - blk_idx steps 0→1→2; exactly one done pulse, 460 cycles after accept.
- n_blocks=0: behaves exactly as n_blocks=1; done pulses 154 cycles after accept.
- start held high continuously:
  - the second job is accepted only on the first IDLE cycle after DONE;
  - start pulses during LOAD/ROUND/WRITE have no effect on counters or addresses.
- Reset mid-operation: assert rst during ROUND at round_idx=10.
  - Next cycle: ready=1, round_en=0, ld_en=0, done never pulses.
  - A new start then runs a clean full sequence from slice 0.
- Address wrap: base_addr=0xFFE0, n_blocks=1 → rd_addr runs 0xFFE0..0xFFFF, then 0x0000..0x001F.
